// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Fetch-unit bus: instruction RAM port, core IF handshake, branch redirect and debug count.
interface fetch_prefetch_unit_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 10
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              inst_ram_en;
  logic [ADDR_W-1:0] inst_ram_addr;
  logic [31:0]       inst_ram_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_inst;
  logic [31:0]       if_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output inst_ram_en, inst_ram_addr, if_valid, if_inst, if_pc, fifo_count,
    input  inst_ram_rdata, if_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  inst_ram_en, inst_ram_addr, if_valid, if_inst, if_pc, fifo_count,
    output inst_ram_rdata, if_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, inst} fetch entries; flush beats push, head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= din;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  // Gate the head so a flushed or reset FIFO presents zeros rather than stale entries.
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues RAM reads against FIFO credit, handles redirects.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 10
) (
  input logic                   clk,
  input logic                   rst,
  fetch_prefetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             pop, push, issue, fifo_full, fifo_empty;
  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] fifo_cnt;
  fetch_entry_t     fifo_din, fifo_head;

  assign pop  = !fifo_empty && bus.if_ready;
  assign push = inflight_q && !bus.redirect_valid;

  // Credit the pop so a full pipeline still issues every cycle.
  assign occupancy = {1'b0, fifo_cnt} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue     = !rst && !bus.redirect_valid && (occupancy < (CNT_W + 1)'(DEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~32'h3;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  assign fifo_din = '{pc: inflight_pc_q, inst: bus.inst_ram_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.inst_ram_en   = issue;
  assign bus.inst_ram_addr = fetch_pc_q[ADDR_W+1:2];
  assign bus.if_valid      = !fifo_empty;
  assign bus.if_inst       = fifo_head.inst;
  assign bus.if_pc         = fifo_head.pc;
  assign bus.fifo_count    = fifo_cnt;

  push_not_full: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full && !pop));
  pop_not_empty: assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty));

endmodule
